// File: rtl/fabric_cfg_pkg.sv
// Shared constants, field offsets and loader state encoding for the fabric
// configuration loader and its shadow register.
package fabric_cfg_pkg;

    localparam int BRB_W      = 900;
    localparam int BSB_W      = 1728;
    localparam int LB_W       = 80;
    localparam int IO_W       = 30;
    localparam int CFG_TOTAL  = BRB_W + BSB_W + LB_W + 4 * IO_W;   // 2828
    localparam int CFG_NBYTES = (CFG_TOTAL + 7) / 8;               // 354
    localparam int CNT_W      = 9;
    localparam int LAST_IDX   = CFG_NBYTES - 1;

    // LSB positions of each select field inside the flat configuration vector
    localparam int BRB_LSB  = 0;
    localparam int BSB_LSB  = BRB_LSB + BRB_W;
    localparam int LB_LSB   = BSB_LSB + BSB_W;
    localparam int LIO_LSB  = LB_LSB + LB_W;
    localparam int RIO_LSB  = LIO_LSB + IO_W;
    localparam int TIO_LSB  = RIO_LSB + IO_W;
    localparam int BIO_LSB  = TIO_LSB + IO_W;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECK,
        ST_COMMIT
    } cfg_state_t;

endpackage

// File: rtl/cfg_shadow_reg.sv
// Byte-addressed shadow register that assembles a configuration frame before
// it is committed; the last byte keeps only its low nibble (the rest is pad).
module cfg_shadow_reg
    import fabric_cfg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CNT_W-1:0]     wr_idx,
    input  logic [7:0]           wr_data,
    output logic [CFG_TOTAL-1:0] shadow_o
);

    for (genvar k = 0; k < CFG_NBYTES; k++) begin : g_byte
        localparam int LSB = 8 * k;
        localparam int W   = (LSB + 8 > CFG_TOTAL) ? (CFG_TOTAL - LSB) : 8;

        logic [W-1:0] byte_q;

        // NOTE: the shadow is a bank of flops rather than a RAM, so it can
        // take a plain synchronous reset to zero like any other register.
        always_ff @(posedge clk) begin
            if (rst) begin
                byte_q <= '0;
            end else if (wr_en && (wr_idx == CNT_W'(k))) begin
                byte_q <= wr_data[W-1:0];
            end
        end

        assign shadow_o[LSB +: W] = byte_q;
    end

endmodule

// File: rtl/fabric_config_loader.sv
// Receives a SYNC-framed, XOR-checked configuration bitstream and commits it
// atomically to the fabric select buses; a failed frame leaves them untouched.
module fabric_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BRB_W-1:0]  brbselect,
    output logic [BSB_W-1:0]  bsbselect,
    output logic [LB_W-1:0]   lbselect,
    output logic [IO_W-1:0]   leftioselect,
    output logic [IO_W-1:0]   rightioselect,
    output logic [IO_W-1:0]   topioselect,
    output logic [IO_W-1:0]   bottomioselect,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    cfg_state_t           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [7:0]           chk_q;
    logic [CFG_TOTAL-1:0] active_q;
    logic [CFG_TOTAL-1:0] shadow;
    logic                 done_q;
    logic                 err_q;
    logic                 xfer;

    // COMMIT is the only state that stalls the stream, so in_ready never
    // looks at in_valid.
    assign in_ready = (state_q != ST_COMMIT);
    assign xfer     = in_valid && in_ready;

    cfg_shadow_reg u_shadow (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (xfer && (state_q == ST_PAYLOAD)),
        .wr_idx   (cnt_q),
        .wr_data  (in_data),
        .shadow_o (shadow)
    );

    // NOTE: all state below is sequential and uses non-blocking assignments
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            chk_q    <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (xfer && (in_data == SYNC_BYTE)) begin
                        state_q <= ST_PAYLOAD;
                        cnt_q   <= '0;
                        chk_q   <= '0;
                        done_q  <= 1'b0;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        chk_q <= chk_q ^ in_data;
                        if (cnt_q == CNT_W'(LAST_IDX)) begin
                            state_q <= ST_CHECK;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (xfer) begin
                        if (in_data == chk_q) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    active_q <= shadow;
                    done_q   <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_busy = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    assign cfg_done = done_q;
    assign cfg_err  = err_q;

    assign brbselect      = active_q[BRB_LSB +: BRB_W];
    assign bsbselect      = active_q[BSB_LSB +: BSB_W];
    assign lbselect       = active_q[LB_LSB  +: LB_W];
    assign leftioselect   = active_q[LIO_LSB +: IO_W];
    assign rightioselect  = active_q[RIO_LSB +: IO_W];
    assign topioselect    = active_q[TIO_LSB +: IO_W];
    assign bottomioselect = active_q[BIO_LSB +: IO_W];

endmodule
